rcv_capture_xfer_if: RTL and testbench
======================================

Name: rcv_capture_xfer_if

Overview:
- Parametrised successor receive interface for the memory read path.
- Captures DQ from the memory on the DQS strobe in DDR or SDR mode, for a configurable lane width. Packs samples into 2*DQ_W words and passes them to the mem_clk domain through an async FIFO.
- Gates capture with a dummy-cycle counter, a programmable preamble-edge skip and an optional word-count limit.
- Adds flush, DQS-timeout detection and a synchronised almost-full indication.

Parameters:
DQ_W, 8, DQ lane width (4, 8 or 16)
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW
DUMMY_W, 5, dummy-cycle counter width
LEN_W, 12, word-count limit width
TIMEOUT_CYC, 64, mem_clk cycles without a DQS write before dqs_timeout sets

Ports:
mem_clk  in  1  system memory clock
reset_n  in  1  reset; asynchronous, active-low; applies to both clock domains
dqs  in  1  read strobe from memory
dq_in  in  DQ_W  read data from memory
start_read  in  1  level; high for the whole read data phase
ddr_mode  in  1  1 = DDR capture, 0 = SDR capture; quasi-static while start_read is high
predrive_en  in  1  memory drives a DQS preamble; enables the preamble skip
preamble_edges  in  2  rising DQS edges to discard when predrive_en = 1
dummy_cycles  in  DUMMY_W  mem_clk cycles to wait after start_read rises
xfer_words  in  LEN_W  words to capture; 0 = unlimited
flush_req  in  1  single-cycle flush request
rd_en  in  1  pop the FIFO head
rd_dout  out  2*DQ_W  FIFO head, show-ahead
rd_empty  out  1  FIFO empty (read domain)
rd_almost_empty  out  1  at most 1 word held
almost_full_sync  out  1  write-side almost-full, 2-flop synchronised to mem_clk
flush_done  out  1  one-cycle pulse at the end of a flush
dqs_timeout  out  1  sticky DQS-absent flag

Behaviour:
Reset values:
- rd_empty = 1, rd_almost_empty = 1; all other outputs 0.
- Every pointer, counter and FSM resets in both domains.
- Asserting reset_n low mid-read aborts capture and empties the FIFO.

mem_clk control:
- start_read_d registers start_read; redge = start_read & !start_read_d.
- dummy_cntr loads dummy_cycles on redge, then decrements to 0 and holds.
- capture_win register = start_read_d & (dummy_cntr == 0) & (flush FSM in IDLE).
- dummy_cycles = 0 opens the window one cycle after redge.
- capture_win feeds the DQS domain directly. It is quasi-static by protocol because it settles during the dummy cycles before the strobe toggles.

DQS domain:
- While capture_win = 0, each DQS edge clears skip_cnt, word_cnt and the SDR phase.
- Preamble skip: when predrive_en = 1, the first preamble_edges rising edges inside the window are discarded.
- DDR packing: sample dq_in on the rising edge into pos_q. On the following falling edge write {dq_in, pos_q}.
- SDR packing: rising edges alternate between holding the low half and the high half. Write on the falling edge after the second rising edge: {second, first}.
- The FIFO write clock is always the falling edge of DQS.
- word_cnt increments per write. Once word_cnt == xfer_words (xfer_words != 0), further writes are suppressed.
- A write while the FIFO is full is dropped. Upstream throttles on almost_full_sync, which asserts at fill >= depth-2.

FIFO:
- Gray-coded pointers with 2-flop cross-domain synchronisers.
- rd_dout is valid whenever rd_empty = 0; rd_en pops next cycle.
- rd_en while empty is ignored.
- Write-to-rd_empty-deassert latency is at most 3 mem_clk cycles.

Timeout:
- tcnt clears on redge and on any change of the synchronised write pointer.
- Otherwise tcnt increments while capture_win = 1, saturating at TIMEOUT_CYC.
- dqs_timeout sets when tcnt reaches TIMEOUT_CYC. It clears on the next redge or on flush_done.

Flush FSM, states IDLE, DRAIN, DONE:
- IDLE -> DRAIN on flush_req. capture_win is forced 0 while not in IDLE.
- DRAIN: internal pops every cycle while not empty; external rd_en is ignored. Move to DONE when rd_empty = 1 and the synchronised write pointer equals the read pointer.
- DONE: flush_done = 1 for one cycle, then IDLE.
- flush_req outside IDLE is ignored.
- flush_req coincident with redge: the flush wins and the window stays closed until IDLE.

Decomposition:
- Package rcv_capture_pkg: flush state enum (IDLE, DRAIN, DONE), default parameter constants, binary/gray conversion functions.
- One sub-module, rcv_async_fifo: dual-clock gray-pointer FIFO with the synchronisers and almost flags.

Test Plan:
- DDR, DQ_W = 8, dummy_cycles = 4, predrive_en = 1, preamble_edges = 2, 8 DQS cycles with bytes 0x00..0x0F -> 6 words 0x0504, 0x0706, ..., 0x0F0E; no write before the window opens.
- SDR, ddr_mode = 0, predrive_en = 0, 8 rising edges with 0xA0..0xA7 -> 4 words 0xA1A0, 0xA3A2, 0xA5A4, 0xA7A6.
- xfer_words = 3, DDR, 10 strobe cycles -> exactly 3 words written; rd_empty asserts after 3 pops.
- Stalled reads with depth 16 -> almost_full_sync = 1 at fill 14; words beyond 16 are dropped; reading back returns the first 16 in order.
- start_read high, no DQS for 64 cycles after the window opens -> dqs_timeout = 1; the next redge clears it.
- flush_req with 5 words held -> FIFO drained, flush_done pulses once, rd_empty = 1; a new read afterwards captures correctly.

Source files
------------

// File: rtl/rcv_capture_pkg.sv
// Shared types, default parameters and pointer-code helpers for the DQS receive path.
// Pointers are converted through a fixed 16-bit container; callers truncate with a cast.
package rcv_capture_pkg;

    localparam int DQ_W_DEF        = 8;
    localparam int FIFO_AW_DEF     = 4;
    localparam int DUMMY_W_DEF     = 5;
    localparam int LEN_W_DEF       = 12;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } flush_state_t;

    typedef logic [15:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = g;
        for (int i = 1; i < $bits(ptr_t); i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rcv_async_fifo.sv
// Dual-clock FIFO with Gray pointers, 2-flop synchronisers, show-ahead read and almost flags.
// Write-side full/almost-full use a read pointer that only advances on write-clock edges.
module rcv_async_fifo
    import rcv_capture_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          wr_clk,
    input  logic          rd_clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_empty,
    output logic          rd_almost_empty,
    output logic          almost_full_sync,
    output logic [AW:0]   wptr_sync,
    output logic [AW:0]   rptr
);
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] AF_LEVEL = PW'(DEPTH - 2);

    logic [DW-1:0] mem [DEPTH];

    logic [AW:0] wbin, wgray, rq1, rq2, rbin_w, wbin_next, fill_next;
    logic        wr_full, wr_go, af_w;
    logic [AW:0] rbin, rgray, wq1, wq2, wbin_r, rbin_next;
    logic        rd_go, af_q1, af_q2;

    // Write domain
    assign rbin_w    = PW'(gray2bin(ptr_t'(rq2)));
    assign wr_full   = (wgray == {~rq2[AW:AW-1], rq2[AW-2:0]});
    assign wr_go     = wr_en & ~wr_full;
    assign wbin_next = wbin + PW'(wr_go);
    assign fill_next = wbin_next - rbin_w;

    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            wbin  <= '0;
            wgray <= '0;
            rq1   <= '0;
            rq2   <= '0;
            af_w  <= 1'b0;
        end else begin
            wbin  <= wbin_next;
            wgray <= PW'(bin2gray(ptr_t'(wbin_next)));
            rq1   <= rgray;
            rq2   <= rq1;
            af_w  <= (fill_next >= AF_LEVEL);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_go) begin
            mem[wbin[AW-1:0]] <= wr_data;
        end
    end

    // Read domain
    assign rd_empty        = (rgray == wq2);
    assign rd_go           = rd_en & ~rd_empty;
    assign rbin_next       = rbin + PW'(rd_go);
    assign wbin_r          = PW'(gray2bin(ptr_t'(wq2)));
    assign rd_almost_empty = ((wbin_r - rbin) <= PW'(1));
    assign rd_data         = mem[rbin[AW-1:0]];

    always_ff @(posedge rd_clk or negedge reset_n) begin
        if (!reset_n) begin
            rbin  <= '0;
            rgray <= '0;
            wq1   <= '0;
            wq2   <= '0;
            af_q1 <= 1'b0;
            af_q2 <= 1'b0;
        end else begin
            rbin  <= rbin_next;
            rgray <= PW'(bin2gray(ptr_t'(rbin_next)));
            wq1   <= wgray;
            wq2   <= wq1;
            af_q1 <= af_w;
            af_q2 <= af_q1;
        end
    end

    assign almost_full_sync = af_q2;
    assign wptr_sync        = wq2;
    assign rptr             = rgray;

endmodule

// File: rtl/rcv_capture_xfer_if.sv
// DQS-strobed DDR/SDR read capture with dummy-cycle gating, preamble skip, word limit,
// flush sequencing and DQS-absence timeout; data crosses to mem_clk through rcv_async_fifo.
module rcv_capture_xfer_if
    import rcv_capture_pkg::*;
#(
    parameter int DQ_W        = DQ_W_DEF,
    parameter int FIFO_AW     = FIFO_AW_DEF,
    parameter int DUMMY_W     = DUMMY_W_DEF,
    parameter int LEN_W       = LEN_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              mem_clk,
    input  logic              reset_n,
    input  logic              dqs,
    input  logic [DQ_W-1:0]   dq_in,
    input  logic              start_read,
    input  logic              ddr_mode,
    input  logic              predrive_en,
    input  logic [1:0]        preamble_edges,
    input  logic [DUMMY_W-1:0] dummy_cycles,
    input  logic [LEN_W-1:0]  xfer_words,
    input  logic              flush_req,
    input  logic              rd_en,
    output logic [2*DQ_W-1:0] rd_dout,
    output logic              rd_empty,
    output logic              rd_almost_empty,
    output logic              almost_full_sync,
    output logic              flush_done,
    output logic              dqs_timeout
);
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYC);

    logic               start_read_d, redge, capture_win;
    logic [DUMMY_W-1:0] dummy_cntr;
    flush_state_t       fstate, fstate_next;
    logic               drain_pop, fifo_pop;
    logic [TCNT_W-1:0]  tcnt, tcnt_next;
    logic               tout_hit;
    logic [FIFO_AW:0]   wptr_sync, wptr_sync_d, rptr_gray;

    logic               dqs_n;
    logic [1:0]         skip_cnt;
    logic               sdr_phase, arm;
    logic [DQ_W-1:0]    pos_q, hi_q;
    logic [LEN_W-1:0]   word_cnt;
    logic               limit_hit, wr_req;
    logic [2*DQ_W-1:0]  wr_data;

    assign redge = start_read & ~start_read_d;

    always_comb begin
        fstate_next = fstate;
        flush_done  = 1'b0;
        drain_pop   = 1'b0;
        case (fstate)
            IDLE: begin
                if (flush_req) fstate_next = DRAIN;
            end
            DRAIN: begin
                drain_pop = ~rd_empty;
                if (rd_empty && (wptr_sync == rptr_gray)) fstate_next = DONE;
            end
            DONE: begin
                flush_done  = 1'b1;
                fstate_next = IDLE;
            end
            default: fstate_next = IDLE;
        endcase
    end

    assign fifo_pop = (fstate == DRAIN) ? drain_pop : rd_en;

    // Timeout counts only while the window is open and the write pointer is idle
    always_comb begin
        tcnt_next = tcnt;
        if (redge || (wptr_sync != wptr_sync_d)) begin
            tcnt_next = '0;
        end else if (capture_win && (tcnt != TCNT_MAX)) begin
            tcnt_next = tcnt + TCNT_W'(1);
        end
    end

    assign tout_hit = (tcnt_next == TCNT_MAX) && (tcnt != TCNT_MAX);

    always_ff @(posedge mem_clk or negedge reset_n) begin
        if (!reset_n) begin
            start_read_d <= 1'b0;
            dummy_cntr   <= '0;
            capture_win  <= 1'b0;
            fstate       <= IDLE;
            tcnt         <= '0;
            wptr_sync_d  <= '0;
            dqs_timeout  <= 1'b0;
        end else begin
            start_read_d <= start_read;
            if (redge) begin
                dummy_cntr <= dummy_cycles;
            end else if (dummy_cntr != '0) begin
                dummy_cntr <= dummy_cntr - DUMMY_W'(1);
            end
            // The window stays shut for the whole flush, including the request cycle
            capture_win <= start_read_d && (dummy_cntr == '0) &&
                           (fstate == IDLE) && (fstate_next == IDLE);
            fstate      <= fstate_next;
            tcnt        <= tcnt_next;
            wptr_sync_d <= wptr_sync;
            if (redge || flush_done) begin
                dqs_timeout <= 1'b0;
            end else if (tout_hit) begin
                dqs_timeout <= 1'b1;
            end
        end
    end

    // Rising-edge sampling; arm marks that the next falling edge completes a word
    always_ff @(posedge dqs or negedge reset_n) begin
        if (!reset_n) begin
            skip_cnt  <= '0;
            sdr_phase <= 1'b0;
            arm       <= 1'b0;
            pos_q     <= '0;
            hi_q      <= '0;
        end else begin
            arm <= 1'b0;
            if (!capture_win) begin
                skip_cnt  <= '0;
                sdr_phase <= 1'b0;
            end else if (predrive_en && (skip_cnt < preamble_edges)) begin
                skip_cnt <= skip_cnt + 2'd1;
            end else if (ddr_mode) begin
                pos_q <= dq_in;
                arm   <= 1'b1;
            end else if (!sdr_phase) begin
                pos_q     <= dq_in;
                sdr_phase <= 1'b1;
            end else begin
                hi_q      <= dq_in;
                sdr_phase <= 1'b0;
                arm       <= 1'b1;
            end
        end
    end

    // The word counter shares the FIFO write clock so its limit check is race-free
    assign dqs_n     = ~dqs;
    assign limit_hit = (xfer_words != '0) && (word_cnt == xfer_words);
    assign wr_req    = capture_win & arm & ~limit_hit;
    assign wr_data   = ddr_mode ? {dq_in, pos_q} : {hi_q, pos_q};

    always_ff @(posedge dqs_n or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt <= '0;
        end else if (!capture_win) begin
            word_cnt <= '0;
        end else if (wr_req) begin
            word_cnt <= word_cnt + LEN_W'(1);
        end
    end

    rcv_async_fifo #(
        .DW (2*DQ_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .wr_clk           (dqs_n),
        .rd_clk           (mem_clk),
        .reset_n          (reset_n),
        .wr_en            (wr_req),
        .wr_data          (wr_data),
        .rd_en            (fifo_pop),
        .rd_data          (rd_dout),
        .rd_empty         (rd_empty),
        .rd_almost_empty  (rd_almost_empty),
        .almost_full_sync (almost_full_sync),
        .wptr_sync        (wptr_sync),
        .rptr             (rptr_gray)
    );

endmodule

// File: tb/tb_rcv_capture_xfer_if.sv
// Scenario bench for rcv_capture_xfer_if: strobe bursts are modelled as a list of
// (rise byte, fall byte) cycles and the expected word stream is derived from those lists.
module tb_rcv_capture_xfer_if;
    localparam int DEPTH = 16;

    logic        mem_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        dqs = 1'b0;
    logic [7:0]  dq_in = '0;
    logic        start_read = 1'b0;
    logic        ddr_mode = 1'b1;
    logic        predrive_en = 1'b0;
    logic [1:0]  preamble_edges = '0;
    logic [4:0]  dummy_cycles = '0;
    logic [11:0] xfer_words = '0;
    logic        flush_req = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_dout;
    logic        rd_empty, rd_almost_empty, almost_full_sync, flush_done, dqs_timeout;

    int checks = 0;
    int errors = 0;

    logic [7:0]  rise_q[$];
    logic [7:0]  fall_q[$];
    logic [15:0] exp_q[$];

    rcv_capture_xfer_if dut (
        .mem_clk          (mem_clk),
        .reset_n          (reset_n),
        .dqs              (dqs),
        .dq_in            (dq_in),
        .start_read       (start_read),
        .ddr_mode         (ddr_mode),
        .predrive_en      (predrive_en),
        .preamble_edges   (preamble_edges),
        .dummy_cycles     (dummy_cycles),
        .xfer_words       (xfer_words),
        .flush_req        (flush_req),
        .rd_en            (rd_en),
        .rd_dout          (rd_dout),
        .rd_empty         (rd_empty),
        .rd_almost_empty  (rd_almost_empty),
        .almost_full_sync (almost_full_sync),
        .flush_done       (flush_done),
        .dqs_timeout      (dqs_timeout)
    );

    always #5 mem_clk = ~mem_clk;

    // One strobe cycle; all edges fall on even times, mem_clk rises on odd times
    task automatic dqs_cycle(input logic [7:0] rb, input logic [7:0] fb);
        dq_in = rb;
        #2 dqs = 1'b1;
        #2 dq_in = fb;
        #2 dqs = 1'b0;
        #2;
    endtask

    task automatic start_burst(input int dummy);
        @(negedge mem_clk);
        dummy_cycles = 5'(dummy);
        start_read = 1'b1;
        // strobe activity during the dummy cycles must never be captured
        repeat (3) dqs_cycle(8'($urandom), 8'($urandom));
        repeat (dummy + 4) @(negedge mem_clk);
    endtask

    task automatic end_burst();
        @(negedge mem_clk);
        start_read = 1'b0;
        repeat (6) @(negedge mem_clk);
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i < hi; i++) dqs_cycle(rise_q[i], fall_q[i]);
    endtask

    task automatic fill_random(input int n);
        rise_q.delete();
        fall_q.delete();
        for (int i = 0; i < n; i++) begin
            rise_q.push_back(8'($urandom));
            fall_q.push_back(8'($urandom));
        end
    endtask

    // Expected stream: drop preamble cycles, pair bytes per mode, cap by limit then capacity
    task automatic build_model(input logic ddr, input logic pre_en, input int pre_n, input int xfer);
        logic [7:0]  acc[$];
        logic [15:0] words[$];
        int skip;
        exp_q.delete();
        skip = pre_en ? pre_n : 0;
        for (int i = skip; i < rise_q.size(); i++) begin
            if (ddr) words.push_back({fall_q[i], rise_q[i]});
            else     acc.push_back(rise_q[i]);
        end
        if (!ddr) begin
            for (int k = 0; k + 1 < acc.size(); k += 2) words.push_back({acc[k+1], acc[k]});
        end
        for (int j = 0; j < words.size(); j++) begin
            if ((xfer == 0 || j < xfer) && j < DEPTH) exp_q.push_back(words[j]);
        end
    endtask

    task automatic read_check(input string name);
        int got = 0;
        int cyc = 0;
        while (got < exp_q.size() && cyc < 200) begin
            @(negedge mem_clk);
            if (!rd_empty) begin
                checks++;
                if (rd_dout !== exp_q[got]) begin
                    errors++;
                    $display("FAIL %s word %0d: got %h expected %h", name, got, rd_dout, exp_q[got]);
                end
                got++;
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
            cyc++;
        end
        @(negedge mem_clk);
        rd_en = 1'b0;
        checks++;
        if (got != exp_q.size()) begin
            errors++;
            $display("FAIL %s read timeout: got %0d words expected %0d", name, got, exp_q.size());
        end
        repeat (5) @(negedge mem_clk);
        checks++;
        if (rd_empty !== 1'b1 || rd_almost_empty !== 1'b1) begin
            errors++;
            $display("FAIL %s drained flags: empty=%b aempty=%b expected 1/1", name, rd_empty, rd_almost_empty);
        end
        $display("%s: %0d words read back", name, got);
    endtask

    task automatic run_burst(input string name, input int dummy);
        start_burst(dummy);
        send_range(0, rise_q.size());
        end_burst();
        build_model(ddr_mode, predrive_en, int'(preamble_edges), int'(xfer_words));
        read_check(name);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge mem_clk);
        checks++;
        if ({rd_empty, rd_almost_empty, almost_full_sync, flush_done, dqs_timeout} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_held flags: got %b expected 11000",
                     {rd_empty, rd_almost_empty, almost_full_sync, flush_done, dqs_timeout});
        end
        reset_n = 1'b1;
        repeat (3) @(negedge mem_clk);
        checks++;
        if ({rd_empty, rd_almost_empty, almost_full_sync, flush_done, dqs_timeout} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_released flags: got %b expected 11000",
                     {rd_empty, rd_almost_empty, almost_full_sync, flush_done, dqs_timeout});
        end
        $display("test_reset done");
    endtask

    task automatic test_ddr_preamble();
        ddr_mode = 1'b1; predrive_en = 1'b1; preamble_edges = 2'd2; xfer_words = '0;
        rise_q.delete(); fall_q.delete();
        for (int i = 0; i < 8; i++) begin
            rise_q.push_back(8'(2*i));
            fall_q.push_back(8'(2*i + 1));
        end
        start_burst(4);
        checks++;
        if (rd_empty !== 1'b1) begin
            errors++;
            $display("FAIL ddr_prewindow rd_empty: got %b expected 1", rd_empty);
        end
        send_range(0, 8);
        end_burst();
        build_model(1'b1, 1'b1, 2, 0);
        read_check("ddr_preamble");
    endtask

    task automatic test_sdr();
        ddr_mode = 1'b0; predrive_en = 1'b0; preamble_edges = '0; xfer_words = '0;
        rise_q.delete(); fall_q.delete();
        for (int i = 0; i < 8; i++) begin
            rise_q.push_back(8'(8'hA0 + i));
            fall_q.push_back(8'($urandom));
        end
        run_burst("sdr", 3);
    endtask

    task automatic test_xfer_limit();
        ddr_mode = 1'b1; predrive_en = 1'b0; xfer_words = 12'd3;
        fill_random(10);
        run_burst("xfer_limit", 3);
        xfer_words = '0;
    endtask

    task automatic test_almost_full();
        ddr_mode = 1'b1; predrive_en = 1'b0; xfer_words = '0;
        fill_random(20);
        start_burst(3);
        send_range(0, 13);
        repeat (4) @(negedge mem_clk);
        checks++;
        if (almost_full_sync !== 1'b0) begin
            errors++;
            $display("FAIL af_at_13: got %b expected 0", almost_full_sync);
        end
        send_range(13, 14);
        repeat (4) @(negedge mem_clk);
        checks++;
        if (almost_full_sync !== 1'b1) begin
            errors++;
            $display("FAIL af_at_14: got %b expected 1", almost_full_sync);
        end
        send_range(14, 20);
        end_burst();
        build_model(1'b1, 1'b0, 0, 0);
        read_check("almost_full");
    endtask

    task automatic test_timeout();
        ddr_mode = 1'b1; predrive_en = 1'b0;
        start_burst(3);
        repeat (45) @(negedge mem_clk);
        checks++;
        if (dqs_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got %b expected 0", dqs_timeout);
        end
        repeat (30) @(negedge mem_clk);
        checks++;
        if (dqs_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_set: got %b expected 1", dqs_timeout);
        end
        end_burst();
        checks++;
        if (dqs_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b expected 1", dqs_timeout);
        end
        start_read = 1'b1;
        repeat (2) @(negedge mem_clk);
        checks++;
        if (dqs_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_redge_clear: got %b expected 0", dqs_timeout);
        end
        end_burst();
        $display("test_timeout done");
    endtask

    task automatic test_flush();
        int pulses = 0;
        ddr_mode = 1'b1; predrive_en = 1'b0; xfer_words = '0;
        fill_random(5);
        start_burst(3);
        send_range(0, 5);
        end_burst();
        checks++;
        if (rd_empty !== 1'b0 || rd_almost_empty !== 1'b0) begin
            errors++;
            $display("FAIL flush_held flags: empty=%b aempty=%b expected 0/0", rd_empty, rd_almost_empty);
        end
        flush_req = 1'b1;
        @(negedge mem_clk);
        flush_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (flush_done === 1'b1) pulses++;
            @(negedge mem_clk);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL flush_done pulses: got %0d expected 1", pulses);
        end
        checks++;
        if (rd_empty !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty: got %b expected 1", rd_empty);
        end
        fill_random(6);
        run_burst("after_flush", 4);
    endtask

    task automatic test_back_to_back();
        @(negedge mem_clk);
        rd_en = 1'b1;
        repeat (3) @(negedge mem_clk);
        rd_en = 1'b0;
        for (int it = 0; it < 6; it++) begin
            ddr_mode       = 1'($urandom);
            predrive_en    = 1'($urandom);
            preamble_edges = 2'($urandom);
            xfer_words     = 12'($urandom_range(0, 8));
            fill_random($urandom_range(4, 10));
            run_burst($sformatf("random_%0d", it), $urandom_range(3, 6));
        end
        xfer_words = '0;
    endtask

    task automatic test_reset_midread();
        ddr_mode = 1'b1; predrive_en = 1'b0; xfer_words = '0;
        fill_random(4);
        start_burst(3);
        send_range(0, 4);
        repeat (4) @(negedge mem_clk);
        checks++;
        if (rd_empty !== 1'b0) begin
            errors++;
            $display("FAIL midread_filled: got %b expected 0", rd_empty);
        end
        reset_n = 1'b0;
        start_read = 1'b0;
        #1;
        checks++;
        if (rd_empty !== 1'b1) begin
            errors++;
            $display("FAIL midread_reset_empty: got %b expected 1", rd_empty);
        end
        repeat (2) @(negedge mem_clk);
        reset_n = 1'b1;
        fill_random(5);
        run_burst("after_reset", 3);
    endtask

    initial begin
        test_reset();
        test_ddr_preamble();
        test_sdr();
        test_xfer_limit();
        test_almost_full();
        test_timeout();
        test_flush();
        test_back_to_back();
        test_reset_midread();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
